// File: rtl/om_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | om_ctrl_pkg                                                        |
// | Shared types for the overflow-memory range-buffer controller.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package om_ctrl_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        LOOKUP = 3'd2,
        RESP   = 3'd3,
        CLEAR  = 3'd4
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] first;
        logic [ADDR_W-1:0] last;
        logic              big;
    } wr_req_t;

endpackage
`default_nettype wire

// File: rtl/om_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | om_rr_arb                                                          |
// | Round-robin arbiter: one-hot candidate grant searched from a       |
// | rotating pointer; pointer advances past the winner when taken.     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module om_rr_arb #(
    parameter int NUM_WR = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_WR-1:0] i_req,
    input  logic              i_update,
    output logic [NUM_WR-1:0] o_gnt
);

    localparam int PTR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_j;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_found;

    // Find the first requester at or after the pointer, wrapping around.
    always_comb begin
        o_gnt   = '0;
        w_idx   = '0;
        w_j     = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            w_j = PTR_W'((int'(r_ptr) + i) % NUM_WR);
            if (!w_found && i_req[w_j]) begin
                w_found     = 1'b1;
                o_gnt[w_j]  = 1'b1;
                w_idx       = w_j;
            end
        end
        w_ptr_nxt = (w_idx == PTR_W'(NUM_WR - 1)) ? '0 : w_idx + 1'b1;
    end

    // Pointer moves one past the winner only when the grant is consumed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (i_update && w_found) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/om_range_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | om_range_ctrl                                                      |
// | Scheduler in front of the overflow-memory range buffer: shares the |
// | write port, sequences lookups and clears, tracks occupancy/errors. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module om_range_ctrl
    import om_ctrl_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int NUM_WR    = 2,
    parameter int WR_STARVE = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_WR-1:0]          wr_req_i,
    output logic [NUM_WR-1:0]          wr_gnt_o,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_first_i,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_last_i,
    input  logic [NUM_WR-1:0]          wr_big_i,
    input  logic                       q_valid_i,
    output logic                       q_ready_o,
    input  logic [ADDR_W-1:0]          q_addr_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic                       rsp_in_range_o,
    output logic                       rsp_is_first_o,
    input  logic                       clr_req_i,
    output logic                       clr_done_o,
    output logic                       buf_en_write_o,
    output logic                       buf_is_big_o,
    output logic [ADDR_W-1:0]          buf_addr_first_o,
    output logic [ADDR_W-1:0]          buf_addr_last_o,
    output logic                       buf_find_o,
    output logic [ADDR_W-1:0]          buf_find_addr_o,
    output logic                       buf_clr_o,
    input  logic                       buf_in_range_i,
    input  logic                       buf_is_first_i,
    output logic [$clog2(SIZE+1)-1:0]  occupancy_o,
    output logic                       full_o,
    output logic                       err_bad_range_o
);

    localparam int OCC_W = $clog2(SIZE + 1);
    localparam int STV_W = (WR_STARVE > 0) ? $clog2(WR_STARVE + 1) : 1;
    localparam logic [OCC_W-1:0] c_occ_full   = OCC_W'(SIZE);
    localparam logic [STV_W-1:0] c_starve_max = STV_W'(WR_STARVE);

    state_t            r_state;
    state_t            w_state_nxt;
    wr_req_t           r_wr;
    wr_req_t           w_sel;
    logic [ADDR_W-1:0] r_q_addr;
    logic              r_in_range;
    logic              r_is_first;
    logic              r_clr_done;
    logic [OCC_W-1:0]  r_occ;
    logic              r_err;
    logic [STV_W-1:0]  r_starve;
    logic [NUM_WR-1:0] w_arb_gnt;
    logic              w_wr_any;
    logic              w_wr_take;
    logic              w_q_take;
    logic              w_bad;

    assign w_wr_any = |wr_req_i;

    om_rr_arb #(
        .NUM_WR (NUM_WR)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_req    (wr_req_i),
        .i_update (w_wr_take),
        .o_gnt    (w_arb_gnt)
    );

    // Route the candidate winner's payload onto a single struct.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (w_arb_gnt[k]) begin
                w_sel.first = wr_first_i[k*ADDR_W +: ADDR_W];
                w_sel.last  = wr_last_i[k*ADDR_W +: ADDR_W];
                w_sel.big   = wr_big_i[k];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and IDLE arbitration: clear, starved write, query, write.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_take   = 1'b0;
        w_q_take    = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr_req_i) begin
                    w_state_nxt = CLEAR;
                end else if (w_wr_any && (r_starve == c_starve_max)) begin
                    w_wr_take = 1'b1;
                end else if (q_valid_i) begin
                    w_q_take    = 1'b1;
                    w_state_nxt = LOOKUP;
                end else if (w_wr_any) begin
                    w_wr_take = 1'b1;
                end
                if (w_wr_take) begin
                    w_bad = (w_sel.first > w_sel.last);
                    if (!w_bad) begin
                        w_state_nxt = WRITE;
                    end
                end
            end
            WRITE:   w_state_nxt = IDLE;
            LOOKUP:  w_state_nxt = RESP;
            RESP:    if (rsp_ready_i) w_state_nxt = IDLE;
            CLEAR:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grants are suppressed while reset is held so no handshake completes.
    assign wr_gnt_o  = (w_wr_take && !rst_i) ? w_arb_gnt : '0;
    assign q_ready_o = w_q_take && !rst_i;

    assign buf_en_write_o   = (r_state == WRITE);
    assign buf_find_o       = (r_state == LOOKUP);
    assign buf_clr_o        = (r_state == CLEAR);
    assign rsp_valid_o      = (r_state == RESP);
    assign buf_addr_first_o = r_wr.first;
    assign buf_addr_last_o  = r_wr.last;
    assign buf_is_big_o     = r_wr.big;
    assign buf_find_addr_o  = r_q_addr;
    assign rsp_in_range_o   = r_in_range;
    assign rsp_is_first_o   = r_is_first;
    assign clr_done_o       = r_clr_done;
    assign occupancy_o      = r_occ;
    assign full_o           = (r_occ == c_occ_full);
    assign err_bad_range_o  = r_err;

    // Datapath: captured write/query payloads, results and status.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr       <= '0;
            r_q_addr   <= '0;
            r_in_range <= 1'b0;
            r_is_first <= 1'b0;
            r_clr_done <= 1'b0;
            r_occ      <= '0;
            r_err      <= 1'b0;
            r_starve   <= '0;
        end else begin
            if (w_wr_take && !w_bad) begin
                r_wr <= w_sel;
            end
            if (w_q_take) begin
                r_q_addr <= q_addr_i;
            end
            if (r_state == LOOKUP) begin
                r_in_range <= buf_in_range_i;
                r_is_first <= buf_is_first_i;
            end
            r_clr_done <= (r_state == CLEAR);
            if (r_state == CLEAR) begin
                r_occ <= '0;
                r_err <= 1'b0;
            end else begin
                if ((r_state == WRITE) && (r_occ != c_occ_full)) begin
                    r_occ <= r_occ + 1'b1;
                end
                if (w_bad) begin
                    r_err <= 1'b1;
                end
            end
            if (w_wr_take || !w_wr_any) begin
                r_starve <= '0;
            end else if ((r_state == IDLE) && (r_starve != c_starve_max)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
